// File: rtl/vector_pkg.sv
// Shared vector-unit types: lane slices, full vector registers, register selectors
// and the writeback-collector entry layout.
package vector_pkg;

  localparam int SLICE_W  = 2;   // elements per lane slice
  localparam int ELEM_W   = 8;
  localparam int LANES    = 16;
  localparam int VLEN     = LANES * SLICE_W;
  localparam int WB_DEPTH = 2;   // default in-flight writeback entries

  typedef logic [4:0]                     vsel_t;
  typedef logic [SLICE_W-1:0][ELEM_W-1:0] slice_t;
  typedef logic [VLEN-1:0][ELEM_W-1:0]    vreg_t;

  typedef struct packed {
    vsel_t              vd;
    vreg_t              vdata;
    logic [LANES-1:0]   filled;
  } wb_entry_t;

endpackage

// File: rtl/vec_wb_ring_ctrl.sv
// Head/tail/occupancy bookkeeping for the in-order writeback ring.
// Allocation is gated on registered occupancy only, so a same-cycle pop never frees a slot.
module vec_wb_ring_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_alloc_valid,
  input  logic                     i_pop,
  output logic                     o_alloc_ready,
  output logic                     o_alloc_fire,
  output logic [$clog2(DEPTH)-1:0] o_head,
  output logic [$clog2(DEPTH)-1:0] o_tail,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_occ;
  logic             w_push;
  logic             w_pop;

  assign o_alloc_ready = (r_occ < FULL) && !i_flush;
  assign w_push        = i_alloc_valid && o_alloc_ready;
  assign w_pop         = i_pop && !i_flush;
  assign o_alloc_fire  = w_push;
  assign o_head        = r_head;
  assign o_tail        = r_tail;
  assign o_occupancy   = r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/vec_wb_collector.sv
// Collects per-lane result slices into in-order vector writeback entries and
// offers each completed head entry to a register-file write port.
module vec_wb_collector
  import vector_pkg::*;
#(
  parameter int DEPTH     = WB_DEPTH,
  parameter int NUM_LANES = LANES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc_valid,
  input  vsel_t                         alloc_vd,
  output logic                          alloc_ready,
  input  logic   [NUM_LANES-1:0]        lane_valid,
  input  slice_t [NUM_LANES-1:0]        lane_result,
  output logic   [NUM_LANES-1:0]        lane_ready,
  output logic                          wb_valid,
  output vsel_t                         wb_vd,
  output vreg_t                         wb_vdata,
  input  logic                          wb_ready,
  output logic   [$clog2(DEPTH):0]      occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_tail;
  logic [PTR_W:0]   w_occ;
  logic             w_alloc_fire;
  logic             w_pop;

  wb_entry_t        r_entry    [DEPTH];
  logic [PTR_W-1:0] r_fill_ptr [NUM_LANES];

  vec_wb_ring_ctrl #(.DEPTH(DEPTH)) u_ring (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (flush),
    .i_alloc_valid (alloc_valid),
    .i_pop         (w_pop),
    .o_alloc_ready (alloc_ready),
    .o_alloc_fire  (w_alloc_fire),
    .o_head        (w_head),
    .o_tail        (w_tail),
    .o_occupancy   (w_occ)
  );

  // Writeback outputs are taken purely from registered entry state.
  assign wb_valid  = (w_occ != '0) && (&r_entry[w_head].filled[NUM_LANES-1:0]);
  assign wb_vd     = r_entry[w_head].vd;
  assign wb_vdata  = r_entry[w_head].vdata;
  assign w_pop     = wb_valid && wb_ready;
  assign occupancy = w_occ;

  // A lane's fill pointer targets an allocated entry when its ring distance
  // from head is below occupancy; a set filled bit means the lane has wrapped.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [PTR_W-1:0] w_dist;
      assign w_dist         = r_fill_ptr[gi] - w_head;
      assign lane_ready[gi] = ({1'b0, w_dist} < w_occ) &&
                              !r_entry[r_fill_ptr[gi]].filled[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) r_entry[e] <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_fill_ptr[l] <= '0;
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) r_entry[e].filled <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_fill_ptr[l] <= '0;
    end else begin
      if (w_alloc_fire) begin
        r_entry[w_tail].vd     <= alloc_vd;
        r_entry[w_tail].filled <= '0;
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_valid[l] && lane_ready[l]) begin
          r_entry[r_fill_ptr[l]].vdata[l*SLICE_W +: SLICE_W] <= lane_result[l];
          r_entry[r_fill_ptr[l]].filled[l]                   <= 1'b1;
          r_fill_ptr[l]                                      <= r_fill_ptr[l] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_wb_collector.sv
// Directed plus randomized bench for vec_wb_collector, checked against a
// queue-based model of in-flight entries and per-lane progress.
module tb_vec_wb_collector;
  import vector_pkg::*;

  localparam int DEPTH = 2;
  localparam int NL    = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush;
  logic                  alloc_valid;
  vsel_t                 alloc_vd;
  logic                  alloc_ready;
  logic   [NL-1:0]       lane_valid;
  slice_t [NL-1:0]       lane_result;
  logic   [NL-1:0]       lane_ready;
  logic                  wb_valid;
  vsel_t                 wb_vd;
  vreg_t                 wb_vdata;
  logic                  wb_ready;
  logic   [1:0]          occupancy;

  vec_wb_collector #(.DEPTH(DEPTH), .NUM_LANES(NL)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_vd    (alloc_vd),
    .alloc_ready (alloc_ready),
    .lane_valid  (lane_valid),
    .lane_result (lane_result),
    .lane_ready  (lane_ready),
    .wb_valid    (wb_valid),
    .wb_vd       (wb_vd),
    .wb_vdata    (wb_vdata),
    .wb_ready    (wb_ready),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  // Model: queue of in-flight entries in allocation order, and per lane the
  // queue index of the next entry that lane still has to deliver.
  typedef struct {
    vsel_t               vd;
    logic [NL-1:0][15:0] slices;
    logic [NL-1:0]       filled;
  } ent_t;

  ent_t q[$];
  int   fidx[NL];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_wbv();
    return (q.size() > 0) && (&q[0].filled);
  endfunction

  function automatic logic [NL-1:0] m_lane_ready();
    logic [NL-1:0] r;
    for (int l = 0; l < NL; l++) r[l] = (fidx[l] < q.size());
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int l = 0; l < NL; l++) fidx[l] = 0;
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_vd    = '0;
    lane_valid  = '0;
    wb_ready    = 1'b0;
  endtask

  // Check outputs against the model with current inputs, advance the model, clock once.
  task automatic tick();
    logic mwv;
    int   s0;
    ent_t e;
    #1;
    mwv = m_wbv();
    chk("alloc_ready", alloc_ready, (q.size() < DEPTH) && !flush);
    chk("lane_ready", lane_ready, m_lane_ready());
    chk("wb_valid", wb_valid, mwv);
    chk("occupancy", occupancy, q.size());
    if (mwv) begin
      chk("wb_vd", wb_vd, q[0].vd);
      chk("wb_vdata", wb_vdata, q[0].slices);
    end
    if (flush) begin
      model_clear();
    end else begin
      s0 = q.size();
      for (int l = 0; l < NL; l++) begin
        if (lane_valid[l] && fidx[l] < s0) begin
          e = q[fidx[l]];
          e.slices[l] = lane_result[l];
          e.filled[l] = 1'b1;
          q[fidx[l]]  = e;
          fidx[l]++;
        end
      end
      if (alloc_valid && s0 < DEPTH) begin
        e.vd     = alloc_vd;
        e.slices = '0;
        e.filled = '0;
        q.push_back(e);
        $display("alloc vd=%0d", alloc_vd);
      end
      if (mwv && wb_ready) begin
        $display("wb    vd=%0d data=%h", q[0].vd, q[0].slices);
        void'(q.pop_front());
        for (int l = 0; l < NL; l++) fidx[l]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(vsel_t vd);
    idle();
    alloc_valid = 1'b1;
    alloc_vd    = vd;
    tick();
    idle();
  endtask

  task automatic fill_lanes(logic [NL-1:0] mask);
    idle();
    lane_valid = mask;
    for (int l = 0; l < NL; l++) lane_result[l] = slice_t'($urandom);
    tick();
    idle();
  endtask

  task automatic drain();
    idle();
    wb_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    idle();
  endtask

  initial begin
    vreg_t exp_v;
    idle();
    lane_result = '0;
    model_clear();

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_wb_vd", wb_vd, 0);
    chk("rst_wb_vdata", wb_vdata, 0);
    chk("rst_lane_ready", lane_ready, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    tick();

    // All lanes complete in one cycle
    do_alloc(5'd5);
    lane_valid = '1;
    for (int i = 0; i < NL; i++) lane_result[i] = {8'(i), 8'(i)};
    tick();
    idle();
    for (int e = 0; e < VLEN; e++) exp_v[e] = 8'(e / 2);
    chk("t034_wb_valid", wb_valid, 1);
    chk("t034_wb_vd", wb_vd, 5);
    chk("t034_wb_vdata", wb_vdata, exp_v);
    drain();

    // Lane 0 runs two entries ahead of the others
    do_alloc(5'd3);
    do_alloc(5'd7);
    lane_valid = 16'h0001;
    lane_result[0] = 16'hA0A1;
    tick();
    lane_result[0] = 16'hB0B1;
    tick();
    tick();
    chk("t035_no_wb", wb_valid, 0);
    fill_lanes(16'hFFFE);
    fill_lanes(16'hFFFE);
    wb_ready = 1'b1;
    chk("t035_first_vd", wb_vd, 3);
    tick();
    chk("t035_second_vd", wb_vd, 7);
    tick();
    idle();
    tick();

    // Backpressure with a full ring, no pop-to-alloc bypass
    do_alloc(5'd1);
    do_alloc(5'd2);
    fill_lanes('1);
    fill_lanes('1);
    alloc_valid = 1'b1;
    alloc_vd    = 5'd12;
    repeat (10) tick();
    wb_ready = 1'b1;
    alloc_vd = 5'd13;
    tick();
    chk("t036_occ_after_pop", occupancy, 1);
    wb_ready = 1'b0;
    tick();
    chk("t036_occ_after_alloc", occupancy, 2);
    idle();
    fill_lanes('1);
    drain();

    // Lane valid with nothing allocated is ignored
    lane_valid = 16'h0010;
    tick();
    chk("t037_lane4_ready", lane_ready[4], 0);
    tick();
    idle();
    do_alloc(5'd6);
    fill_lanes(16'hFFEF);
    tick();
    chk("t037_incomplete", wb_valid, 0);
    fill_lanes(16'h0010);
    chk("t037_complete", wb_valid, 1);
    drain();

    // Flush discards a 15/16 entry
    do_alloc(5'd11);
    fill_lanes(16'h7FFF);
    flush = 1'b1;
    tick();
    idle();
    chk("t038_occ", occupancy, 0);
    repeat (3) tick();
    chk("t038_no_wb", wb_valid, 0);
    do_alloc(5'd9);
    fill_lanes('1);
    chk("t038_wb_vd", wb_vd, 9);
    drain();

    // Asynchronous reset with a completed entry pending
    do_alloc(5'd4);
    fill_lanes('1);
    tick();
    chk("t039_pending", wb_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t039_wb_valid", wb_valid, 0);
    chk("t039_occ", occupancy, 0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Randomized traffic
    repeat (400) begin
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_vd    = vsel_t'($urandom);
      lane_valid  = NL'($urandom);
      for (int l = 0; l < NL; l++) lane_result[l] = slice_t'($urandom);
      wb_ready    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vec_wb_collector.md
VEC_WB_COLLECTOR -- requirements
Module: vec_wb_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of in-flight result entries (power of two, >=2).
REQ-002 SHALL have parameter NUM_LANES, default 16, lanes reporting slices; SLICE_W (2) and vreg width come from vector_pkg.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of all entries and pointers.
REQ-006 alloc_valid  input  1  issue stage requests a result entry.
REQ-007 alloc_vd  input  vsel_t  destination vector register for the entry.
REQ-008 alloc_ready  output  1  entry available (occupancy < DEPTH and not flush).
REQ-009 lane_valid  input  NUM_LANES  per-lane slice result valid.
REQ-010 lane_result  input  NUM_LANES x slice_t  per-lane result slice.
REQ-011 lane_ready  output  NUM_LANES  per-lane slice accept.
REQ-012 wb_valid  output  1  completed entry offered to a VEGGIE write port.
REQ-013 wb_vd  output  vsel_t  destination register of the head entry.
REQ-014 wb_vdata  output  vreg_t  assembled vector; lane i drives elements [i*SLICE_W +: SLICE_W].
REQ-015 wb_ready  input  1  VEGGIE write port accepts.
REQ-016 occupancy  output  $clog2(DEPTH)+1  allocated entry count.

Function
REQ-017 Entries form an in-order ring: tail pointer advances on alloc_valid && alloc_ready; head pointer advances on wb_valid && wb_ready; both wrap at DEPTH.
REQ-018 Each entry holds vd, vdata, and a NUM_LANES-bit filled bitmap cleared on allocation.
REQ-019 Each lane owns a fill pointer; lane_ready[i] = 1 when the entry at lane i's fill pointer is allocated and its filled[i] bit is 0.
REQ-020 On lane_valid[i] && lane_ready[i], lane_result[i] is written to slice i of that entry, filled[i] set, and lane i's fill pointer advances (wrapping at DEPTH).
REQ-021 lane_valid[i] while lane_ready[i] = 0 SHALL be ignored with no state change.
REQ-022 Lanes complete independently; lane i may run up to DEPTH entries ahead of lane j.
REQ-023 wb_valid SHALL be 1 exactly when the head entry is allocated and all filled bits are 1; wb_vd/wb_vdata come from the head entry, registered (no combinational path from lane_* to wb_*).
REQ-024 Latency: final slice accepted at edge N -> wb_valid high in the cycle after edge N.
REQ-025 wb_valid, wb_vd, wb_vdata SHALL hold stable while wb_valid && !wb_ready.
REQ-026 alloc_ready depends only on registered occupancy; same-cycle pop does not free a slot for allocation (no bypass).
REQ-027 Simultaneous alloc and pop SHALL leave occupancy unchanged; both pointers advance.
REQ-028 A lane write and an allocation to the same entry in one cycle cannot occur (lane_ready requires prior allocation).
REQ-029 flush SHALL take priority over alloc, lane writes, and pop: occupancy, pointers, fill pointers, and bitmaps go to 0 next edge; wb_valid low next cycle.

Reset
REQ-030 On RST: occupancy 0, head/tail/fill pointers 0, bitmaps 0, wb_valid 0, wb_vd 0, wb_vdata 0, lane_ready 0, alloc_ready 1 after release.
REQ-031 RST asserted mid-operation SHALL discard all partial and complete entries without emitting wb_valid.

Structure
REQ-032 A wb_entry_t struct (vd, vreg_t vdata, filled bitmap) and a DEPTH constant SHALL be added to vector_pkg; slice_t, vreg_t, vsel_t reused.
REQ-033 One sub-module, vec_wb_ring_ctrl, SHALL hold head/tail/occupancy logic; data storage and lane fill pointers remain in the top.

Verification
REQ-034 Alloc vd=5; all 16 lanes valid same cycle with slice i = {i,i} -> wb_valid next cycle, wb_vd=5, element 2i and 2i+1 = i.
REQ-035 Alloc vd=3 and vd=7; lane 0 delivers both slices before lanes 1-15 deliver any -> wb vd=3 then vd=7, in order, correct data.
REQ-036 Two entries allocated, wb_ready=0 -> alloc_ready=0, wb outputs stable 10 cycles; wb_ready=1 with alloc_valid same cycle -> pop, occupancy stays 2 only after next alloc accepted.
REQ-037 lane_valid[4] with no allocation -> lane_ready[4]=0, no bitmap change, no wb_valid.
REQ-038 Entry with 15/16 slices filled, flush asserted -> occupancy 0, wb_valid never asserts; new alloc vd=9 completes normally.
REQ-039 RST pulsed with one complete entry pending wb_ready -> wb_valid 0 immediately, occupancy 0.
